// File: rtl/tm1638_keys_decoder_pkg.sv
// Shared types and helpers for the TM1638 key-scan decoder.
package tm1638_types;

  localparam int unsigned TM1638_KEYS = 8;

  typedef logic [TM1638_KEYS-1:0] keys_t;

  // "repeat" is a reserved word, hence is_repeat
  typedef struct packed {
    logic [2:0] key;
    logic       press;
    logic       is_repeat;
  } tm1638_key_event_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_UPDATE,
    ST_EMIT
  } dec_state_e;

  // Key 2b lives in bit 0 of scan byte b, key 2b+1 in bit 4 of the same byte.
  function automatic keys_t tm1638_decode_keys(input logic [31:0] data);
    keys_t k;
    for (int unsigned b = 0; b < 4; b++) begin
      k[2*b]   = data[8*b];
      k[2*b+1] = data[8*b+4];
    end
    return k;
  endfunction

endpackage

// File: rtl/tm1638_keys_decoder_event_fifo.sv
// Small synchronous event FIFO; a push into a full FIFO is accepted only
// when a pop happens in the same cycle, otherwise it is discarded.
module tm1638_event_fifo #(
  parameter int unsigned WIDTH = 5,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_pop, do_push;

  assign empty    = (count_q == '0);
  assign full     = (count_q == FULL_CNT);
  assign pop_data = mem_q[rd_ptr_q];

  // Pointer, occupancy and storage update; pop is resolved before push
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    do_pop   = pop && !empty;
    do_push  = push && (!full || do_pop);
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/tm1638_keys_decoder.sv
// TM1638 front-panel key decoder: decodes raw scan words, debounces each
// key over consecutive scans and queues press/release events.
// Optional auto-repeat events are built when TM1638_KEYS_REPEAT_EN is defined.
module tm1638_keys_decoder
  import tm1638_types::*;
#(
  parameter int unsigned SPI_READ_WIDTH      = 32,
  parameter int unsigned DEBOUNCE_SCANS      = 3,
  parameter int unsigned FIFO_DEPTH          = 4
`ifdef TM1638_KEYS_REPEAT_EN
  ,
  parameter int unsigned REPEAT_DELAY_SCANS  = 20,
  parameter int unsigned REPEAT_PERIOD_SCANS = 5
`endif
) (
  input  logic                      i_Clk,
  input  logic                      i_Rst_n,
  input  logic                      i_Data_Valid,
  input  logic [SPI_READ_WIDTH-1:0] i_Data,
  output logic [7:0]                o_Keys,
  output logic                      o_Event_Valid,
  input  logic                      i_Event_Ready,
  output logic [2:0]                o_Event_Key,
  output logic                      o_Event_Press,
  output logic                      o_Event_Repeat,
  output logic                      o_Overflow
);

  localparam int unsigned CNT_W = (DEBOUNCE_SCANS > 1) ? $clog2(DEBOUNCE_SCANS + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_SCANS - 1);

  dec_state_e        state_q, state_d;
  keys_t             pending_q, pending_d;
  logic              pending_valid_q, pending_valid_d;
  keys_t             raw_q, raw_d;
  keys_t             stable_q, stable_d;
  logic [CNT_W-1:0]  cnt_q [TM1638_KEYS];
  logic [CNT_W-1:0]  cnt_d [TM1638_KEYS];
  keys_t             change_q, change_d;
  logic [2:0]        idx_q, idx_d;
  logic              overflow_q, overflow_d;

  logic              ev_push;
  tm1638_key_event_t ev_push_data;
  tm1638_key_event_t head;
  logic              fifo_full, fifo_empty;

`ifdef TM1638_KEYS_REPEAT_EN
  localparam int unsigned HOLD_W = $clog2(REPEAT_DELAY_SCANS + REPEAT_PERIOD_SCANS + 1);
  localparam logic [HOLD_W-1:0] HOLD_DELAY = HOLD_W'(REPEAT_DELAY_SCANS);
  localparam logic [HOLD_W-1:0] HOLD_WRAP  = HOLD_W'(REPEAT_DELAY_SCANS + REPEAT_PERIOD_SCANS - 1);

  logic [HOLD_W-1:0] hold_q [TM1638_KEYS];
  logic [HOLD_W-1:0] hold_d [TM1638_KEYS];
  logic [HOLD_W-1:0] hold_nxt;
  keys_t             rpt_q, rpt_d;
`endif

  // Skid capture, debounce update, event walk and overflow tracking
  always_comb begin
    state_d         = state_q;
    pending_d       = pending_q;
    pending_valid_d = pending_valid_q;
    raw_d           = raw_q;
    stable_d        = stable_q;
    cnt_d           = cnt_q;
    change_d        = change_q;
    idx_d           = idx_q;
    ev_push         = 1'b0;
    ev_push_data    = '0;
`ifdef TM1638_KEYS_REPEAT_EN
    hold_d          = hold_q;
    rpt_d           = rpt_q;
    hold_nxt        = '0;
`endif

    // the pending word is consumed by IDLE; a same-cycle strobe refills it
    if (state_q == ST_IDLE && pending_valid_q) begin
      pending_valid_d = 1'b0;
    end
    if (i_Data_Valid) begin
      pending_d       = tm1638_decode_keys(i_Data);
      pending_valid_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (pending_valid_q) begin
          raw_d   = pending_q;
          state_d = ST_UPDATE;
        end
      end

      ST_UPDATE: begin
        change_d = '0;
        for (int unsigned k = 0; k < TM1638_KEYS; k++) begin
          if (raw_q[k] != stable_q[k]) begin
            if (cnt_q[k] == CNT_LAST) begin
              stable_d[k] = ~stable_q[k];
              cnt_d[k]    = '0;
              change_d[k] = 1'b1;
            end else begin
              cnt_d[k] = cnt_q[k] + CNT_W'(1);
            end
          end else begin
            cnt_d[k] = '0;
          end
        end
`ifdef TM1638_KEYS_REPEAT_EN
        // hold counts scans with the key stably pressed; after the first
        // repeat it cycles DELAY..DELAY+PERIOD-1 so each return to DELAY repeats
        rpt_d = '0;
        for (int unsigned k = 0; k < TM1638_KEYS; k++) begin
          if (!stable_d[k]) begin
            hold_d[k] = '0;
          end else begin
            hold_nxt  = (hold_q[k] == HOLD_WRAP) ? HOLD_DELAY : hold_q[k] + HOLD_W'(1);
            hold_d[k] = hold_nxt;
            rpt_d[k]  = (hold_nxt == HOLD_DELAY) && !change_d[k];
          end
        end
        if ((change_d | rpt_d) == '0) begin
`else
        if (change_d == '0) begin
`endif
          state_d = ST_IDLE;
        end else begin
          state_d = ST_EMIT;
          idx_d   = '0;
        end
      end

      ST_EMIT: begin
        if (change_q[idx_q]) begin
          ev_push      = 1'b1;
          ev_push_data = '{key: idx_q, press: stable_q[idx_q], is_repeat: 1'b0};
        end
`ifdef TM1638_KEYS_REPEAT_EN
        else if (rpt_q[idx_q]) begin
          ev_push      = 1'b1;
          ev_push_data = '{key: idx_q, press: 1'b1, is_repeat: 1'b1};
        end
`endif
        idx_d = idx_q + 3'd1;
        if (idx_q == 3'd7) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // a push into a full FIFO survives only if the head leaves this cycle
    overflow_d = overflow_q | (ev_push & fifo_full & ~i_Event_Ready);
  end

  // Decoder state registers
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q         <= ST_IDLE;
      pending_q       <= '0;
      pending_valid_q <= 1'b0;
      raw_q           <= '0;
      stable_q        <= '0;
      cnt_q           <= '{default: '0};
      change_q        <= '0;
      idx_q           <= '0;
      overflow_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      pending_q       <= pending_d;
      pending_valid_q <= pending_valid_d;
      raw_q           <= raw_d;
      stable_q        <= stable_d;
      cnt_q           <= cnt_d;
      change_q        <= change_d;
      idx_q           <= idx_d;
      overflow_q      <= overflow_d;
    end
  end

`ifdef TM1638_KEYS_REPEAT_EN
  // Hold counters and pending repeat mask
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      hold_q <= '{default: '0};
      rpt_q  <= '0;
    end else begin
      hold_q <= hold_d;
      rpt_q  <= rpt_d;
    end
  end
`endif

  tm1638_event_fifo #(
    .WIDTH($bits(tm1638_key_event_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (i_Clk),
    .rst_n     (i_Rst_n),
    .push      (ev_push),
    .push_data (ev_push_data),
    .full      (fifo_full),
    .pop       (i_Event_Ready),
    .pop_data  (head),
    .empty     (fifo_empty)
  );

  assign o_Keys         = stable_q;
  assign o_Event_Valid  = ~fifo_empty;
  assign o_Event_Key    = head.key;
  assign o_Event_Press  = head.press;
  // only ever written as 1 by repeat pushes, so it reads 0 without the feature
  assign o_Event_Repeat = head.is_repeat;
  assign o_Overflow     = overflow_q;

endmodule

// File: tb/tb_tm1638_keys_decoder.sv
// Scoreboard bench for tm1638_keys_decoder: a scan-level key model pushes
// expected events; a monitor pops and compares on every accepted event.
`timescale 1ns/1ps
module tb_tm1638_keys_decoder;

  localparam int unsigned DEB     = 3;
  localparam int unsigned DEPTH   = 4;
  localparam int          RDELAY  = 20;
  localparam int          RPERIOD = 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dv = 1'b0;
  logic [31:0] data = '0;
  logic        ready = 1'b0;
  logic [7:0]  o_keys;
  logic        o_valid, o_press, o_rpt, o_ovf;
  logic [2:0]  o_key;

  always #5 clk = ~clk;

  tm1638_keys_decoder #(
    .SPI_READ_WIDTH(32),
    .DEBOUNCE_SCANS(DEB),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .i_Clk          (clk),
    .i_Rst_n        (rst_n),
    .i_Data_Valid   (dv),
    .i_Data         (data),
    .o_Keys         (o_keys),
    .o_Event_Valid  (o_valid),
    .i_Event_Ready  (ready),
    .o_Event_Key    (o_key),
    .o_Event_Press  (o_press),
    .o_Event_Repeat (o_rpt),
    .o_Overflow     (o_ovf)
  );

  typedef struct {
    int key;
    bit press;
    bit rpt;
  } ev_t;

  ev_t  exp_q[$];
  int   checks = 0;
  int   failures = 0;
  bit   m_stable[8];
  int   m_cnt[8];
  int   m_hold[8];
  bit   track_occ = 0;
  int   occ = 0;
  bit   exp_ovf = 0;
  bit   rand_ready = 0;
  logic [7:0] tgt = '0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endfunction

  function automatic void add_event(input int k, input bit press, input bit rpt);
    ev_t e;
    e.key = k; e.press = press; e.rpt = rpt;
    if (track_occ) begin
      if (occ < int'(DEPTH)) begin
        exp_q.push_back(e);
        occ++;
      end else begin
        exp_ovf = 1;
      end
    end else begin
      exp_q.push_back(e);
    end
  endfunction

  // Applies one scan word to the key model; returns the number of events it yields.
  function automatic int model_step(input logic [31:0] d, input bit commit);
    bit st[8];
    int cn[8];
    int hd[8];
    int n = 0;
    bit raw, chg;
    for (int k = 0; k < 8; k++) begin
      st[k] = m_stable[k]; cn[k] = m_cnt[k]; hd[k] = m_hold[k];
    end
    for (int k = 0; k < 8; k++) begin
      raw = d[(k / 2) * 8 + (k % 2) * 4];
      chg = 0;
      if (raw != st[k]) begin
        cn[k]++;
        if (cn[k] == int'(DEB)) begin
          st[k] = raw; cn[k] = 0; chg = 1;
        end
      end else begin
        cn[k] = 0;
      end
      if (chg) begin
        n++;
        if (commit) add_event(k, st[k], 0);
      end
`ifdef TM1638_KEYS_REPEAT_EN
      if (!st[k]) hd[k] = 0;
      else begin
        hd[k]++;
        if (!chg && hd[k] >= RDELAY && (hd[k] - RDELAY) % RPERIOD == 0) begin
          n++;
          if (commit) add_event(k, 1, 1);
        end
      end
`endif
    end
    if (commit) begin
      for (int k = 0; k < 8; k++) begin
        m_stable[k] = st[k]; m_cnt[k] = cn[k]; m_hold[k] = hd[k];
      end
    end
    return n;
  endfunction

  function automatic logic [7:0] model_keys();
    logic [7:0] r;
    for (int k = 0; k < 8; k++) r[k] = m_stable[k];
    return r;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 8; k++) begin
      m_stable[k] = 0; m_cnt[k] = 0; m_hold[k] = 0;
    end
    exp_q.delete();
    exp_ovf = 0;
    occ = 0;
  endfunction

  function automatic logic [31:0] gen_scan();
    logic [7:0]  kk;
    logic [31:0] d;
    int          idx;
    if ($urandom_range(0, 3) == 0) tgt = 8'($urandom);
    kk = tgt;
    if ($urandom_range(0, 7) == 0) begin
      idx = int'($urandom_range(0, 7));
      kk[idx] = ~kk[idx];
    end
    d = $urandom & ~32'h1111_1111;
    for (int k = 0; k < 8; k++) d[(k / 2) * 8 + (k % 2) * 4] = kk[k];
    return d;
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (rand_ready) ready = ($urandom_range(0, 1) == 1);
    end
  endtask

  task automatic issue_scan(input logic [31:0] d);
    void'(model_step(d, 1));
    data = d;
    dv = 1'b1;
    step(1);
    dv = 1'b0;
    data = $urandom;
    step(14);
    chk("keys", 32'(o_keys), 32'(model_keys()));
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || o_valid) && t < 300) begin
      step(1);
      t++;
    end
    chk("drain_in_time", 32'(t < 300), 32'd1);
  endtask

  // Monitor: compares each accepted event and checks head stability under backpressure
  bit         was_stalled = 0;
  logic [2:0] st_key;
  logic       st_press, st_rpt;
  always @(negedge clk) begin
    ev_t e;
    if (!rst_n) begin
      was_stalled = 0;
    end else begin
      if (was_stalled) begin
        chk("stall_valid", 32'(o_valid), 32'd1);
        chk("stall_key", 32'(o_key), 32'(st_key));
        chk("stall_press", 32'(o_press), 32'(st_press));
        chk("stall_repeat", 32'(o_rpt), 32'(st_rpt));
      end
      was_stalled = o_valid && !ready;
      st_key = o_key; st_press = o_press; st_rpt = o_rpt;
      if (o_valid && ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_event actual=key%0d/p%0d/r%0d expected=none", o_key, o_press, o_rpt);
        end else begin
          e = exp_q.pop_front();
          if (int'(o_key) != e.key || o_press != e.press || o_rpt != e.rpt) begin
            failures++;
            $display("FAIL event actual=key%0d/p%0d/r%0d expected=key%0d/p%0d/r%0d",
                     o_key, o_press, o_rpt, e.key, e.press, e.rpt);
          end
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int n;
    logic [31:0] d;
    model_reset();

    // reset state
    step(3);
    chk("rst_keys", 32'(o_keys), 32'h0);
    chk("rst_valid", 32'(o_valid), 32'h0);
    chk("rst_ovf", 32'(o_ovf), 32'h0);
    rst_n = 1'b1;
    step(2);
    ready = 1'b1;

    // single key press, with first-event latency
    issue_scan(32'h0000_0001);
    issue_scan(32'h0000_0001);
    void'(model_step(32'h0000_0001, 1));
    data = 32'h0000_0001; dv = 1'b1;
    step(1);
    dv = 1'b0;
    lat = 0;
    while (!o_valid && lat < 10) begin
      step(1);
      lat++;
    end
    chk("latency", 32'(lat), 32'd3);
    step(12);
    chk("keys_after_press", 32'(o_keys), 32'h01);
    issue_scan(32'h0000_0001);
    issue_scan(32'h0000_0001);
    repeat (3) issue_scan(32'h0);

    // glitch shorter than the debounce window
    issue_scan(32'h0000_1000);
    issue_scan(32'h0000_1000);
    issue_scan(32'h0);
    chk("keys_glitch", 32'(o_keys), 32'h00);

    // simultaneous changes in ascending key order
    repeat (3) issue_scan(32'h1000_1001);
    repeat (3) issue_scan(32'h0);

    // random scans, consumer always ready
    for (int i = 0; i < 40; i++) issue_scan(gen_scan());
    repeat (3) issue_scan(32'h0);
    drain();

    // random scans under random backpressure, never more events in flight than fit
    rand_ready = 1;
    for (int i = 0; i < 40; i++) begin
      d = gen_scan();
      n = model_step(d, 0);
      if (n <= int'(DEPTH)) begin
        if (exp_q.size() + n > int'(DEPTH)) drain();
        issue_scan(d);
      end
    end
    drain();
    rand_ready = 0;
    ready = 1'b1;
    repeat (3) issue_scan(32'h0);
    drain();
    chk("ovf_clear", 32'(o_ovf), 32'h0);

    // overflow: six events into a stalled FIFO
    ready = 1'b0;
    track_occ = 1;
    occ = 0;
    repeat (3) issue_scan(32'h0000_0011);
    repeat (3) issue_scan(32'h0000_0010);
    repeat (3) issue_scan(32'h0000_0000);
    repeat (3) issue_scan(32'h0000_0100);
    repeat (3) issue_scan(32'h0000_0000);
    chk("ovf_set", 32'(o_ovf), 32'(exp_ovf));
    chk("full_valid", 32'(o_valid), 32'h1);
    ready = 1'b1;
    drain();
    track_occ = 0;
    chk("ovf_sticky", 32'(o_ovf), 32'h1);

    // asynchronous reset in the middle of the event walk
    ready = 1'b0;
    issue_scan(32'h1111_1111);
    issue_scan(32'h1111_1111);
    data = 32'h1111_1111; dv = 1'b1;
    step(1);
    dv = 1'b0;
    step(3);
    chk("pre_rst_valid", 32'(o_valid), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_keys", 32'(o_keys), 32'h0);
    chk("arst_valid", 32'(o_valid), 32'h0);
    chk("arst_ovf", 32'(o_ovf), 32'h0);
    chk("arst_key", 32'({o_key, o_press, o_rpt}), 32'h0);
    model_reset();
    step(2);
    rst_n = 1'b1;
    ready = 1'b1;
    step(20);
    chk("post_rst_valid", 32'(o_valid), 32'h0);
    chk("post_rst_keys", 32'(o_keys), 32'h0);
    repeat (3) issue_scan(32'h0000_0001);
    repeat (3) issue_scan(32'h0);
    drain();

`ifdef TM1638_KEYS_REPEAT_EN
    // long hold of key 5 with auto-repeat, then release
    repeat (30) issue_scan(32'h0010_0000);
    repeat (3) issue_scan(32'h0);
    drain();
`endif

    chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
